// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if
//   Bundles the two buses of the nibble-serial add controller:
//     request side : start, op_a, op_b, cin  -> ready, done, sum, cout
//     adder side   : fa_a, fa_b, fa_cin       -> fa_s, fa_cout (combinational adder)
//   slave  : the controller
//   master : its environment (requesting datapath plus the shared 4-bit adder)
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [3:0]       fa_a;
   logic [3:0]       fa_b;
   logic             fa_cin;
   logic [3:0]       fa_s;
   logic             fa_cout;

   modport master (
      output start, op_a, op_b, cin, fa_s, fa_cout,
      input  ready, done, sum, cout, fa_a, fa_b, fa_cin
   );

   modport slave (
      input  start, op_a, op_b, cin, fa_s, fa_cout,
      output ready, done, sum, cout, fa_a, fa_b, fa_cin
   );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Adds two WIDTH-bit operands by time-sharing one external 4-bit adder,
//   one nibble per clock, LSB nibble first. {cout,sum} = op_a + op_b + cin.
//   Ports:
//     clk, rst_n : rising-edge clock, asynchronous active-low reset
//     bus.slave  : start/op_a/op_b/cin in, ready/done/sum/cout out,
//                  fa_a/fa_b/fa_cin out to the adder, fa_s/fa_cout back from it
//   Latency: accept edge E0, result registered at E(NIB), done high one
//   cycle, ready again at E(NIB+1).
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   nibble_serial_add_ctrl_if.slave bus
);
   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] work_nxt;

   // New adder nibble enters at the top; after NIB steps the LSB nibble has
   // walked down to bit 0. Cast-of-shift also covers WIDTH==4 (no slice).
   assign work_nxt = WIDTH'({bus.fa_s, work_q} >> 4);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               carry_d = bus.cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            work_d  = work_nxt;
            carry_d = bus.fa_cout;
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               sum_d   = work_nxt;
               cout_d  = bus.fa_cout;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   // Handshake and adder drive decode from state only; adder inputs are
   // parked at zero outside RUN.
   assign bus.ready  = (state_q == IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.sum    = sum_q;
   assign bus.cout   = cout_q;
   assign bus.fa_a   = (state_q == RUN) ? a_q[3:0] : 4'h0;
   assign bus.fa_b   = (state_q == RUN) ? b_q[3:0] : 4'h0;
   assign bus.fa_cin = (state_q == RUN) ? carry_q  : 1'b0;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nibble_serial_add_ctrl_if #(.WIDTH(16)) i16 ();
   nibble_serial_add_ctrl_if #(.WIDTH(4))  i4 ();

   nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
   nibble_serial_add_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(i4.slave));

   // external 4-bit ripple adders
   assign {i16.fa_cout, i16.fa_s} = 5'(i16.fa_a) + 5'(i16.fa_b) + 5'(i16.fa_cin);
   assign {i4.fa_cout,  i4.fa_s}  = 5'(i4.fa_a)  + 5'(i4.fa_b)  + 5'(i4.fa_cin);

   logic [16:0] exp16[$];
   logic [8:0]  nib16[$];
   logic [4:0]  exp4[$];

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // adder inputs expected during RUN step k: operand nibbles and the carry into that nibble
   function automatic logic [8:0] nib_exp(input logic [15:0] a, input logic [15:0] b, input logic c, input int k);
      logic [16:0] m;
      logic [16:0] lo;
      m  = (17'd1 << (4 * k)) - 17'd1;
      lo = ({1'b0, a} & m) + ({1'b0, b} & m) + 17'(c);
      return {a[4*k +: 4], b[4*k +: 4], lo[4*k]};
   endfunction

   // ---------------- monitors ----------------
   int          run16 = 0, run4 = 0;
   bit          pd16 = 0, pd4 = 0;
   logic [16:0] e16;
   logic [8:0]  n16;
   logic [4:0]  e4;

   always @(negedge clk) if (mon_en && rst_n) begin
      if (i16.done) begin
         chk(run16 == 4, "latency16", run16, 4);
         chk({i16.fa_a, i16.fa_b, i16.fa_cin} == 9'h0, "fa_zero_done16", {i16.fa_a, i16.fa_b, i16.fa_cin}, 0);
         if (exp16.size() == 0) chk(1'b0, "unexpected_done16", {i16.cout, i16.sum}, 0);
         else begin
            e16 = exp16.pop_front();
            chk({i16.cout, i16.sum} == e16, "result16", {i16.cout, i16.sum}, e16);
         end
      end else if (pd16) chk(i16.ready, "ready_after_done16", i16.ready, 1);
      pd16 = i16.done;
      if (i16.ready) run16 = 0;
      else if (!i16.done) begin
         run16++;
         if (nib16.size() == 0) chk(1'b0, "unexpected_run16", {i16.fa_a, i16.fa_b, i16.fa_cin}, 0);
         else begin
            n16 = nib16.pop_front();
            chk({i16.fa_a, i16.fa_b, i16.fa_cin} == n16, "fa_inputs16", {i16.fa_a, i16.fa_b, i16.fa_cin}, n16);
         end
      end
   end

   always @(negedge clk) if (mon_en && rst_n) begin
      if (i4.done) begin
         chk(run4 == 1, "latency4", run4, 1);
         if (exp4.size() == 0) chk(1'b0, "unexpected_done4", {i4.cout, i4.sum}, 0);
         else begin
            e4 = exp4.pop_front();
            chk({i4.cout, i4.sum} == e4, "result4", {i4.cout, i4.sum}, e4);
         end
      end else if (pd4) chk(i4.ready, "ready_after_done4", i4.ready, 1);
      pd4 = i4.done;
      if (i4.ready) run4 = 0;
      else if (!i4.done) run4++;
   end

   // ---------------- drivers ----------------
   task automatic wait_ready(input bit w4);
      int n = 0;
      @(negedge clk);
      while (!(w4 ? i4.ready : i16.ready) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!(w4 ? i4.ready : i16.ready)) chk(1'b0, "ready_timeout", 0, 1);
   endtask

   // nn = number of RUN steps the monitor will see; a full op also expects a result
   task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [16:0] res, input int nn);
      wait_ready(1'b0);
      i16.op_a = a; i16.op_b = b; i16.cin = c; i16.start = 1'b1;
      if (nn == 4) exp16.push_back(res);
      for (int k = 0; k < nn; k++) nib16.push_back(nib_exp(a, b, c, k));
      @(negedge clk);
      i16.start = 1'b0; i16.op_a = ~a; i16.op_b = ~b; i16.cin = ~c;
   endtask

   task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] res);
      wait_ready(1'b1);
      i4.op_a = a; i4.op_b = b; i4.cin = c; i4.start = 1'b1;
      exp4.push_back(res);
      @(negedge clk);
      i4.start = 1'b0; i4.op_a = ~a; i4.op_b = ~b; i4.cin = ~c;
   endtask

   task automatic check_reset(input string tag);
      chk(i16.ready == 1'b1, {tag, "_ready16"}, i16.ready, 1);
      chk(i16.done == 1'b0, {tag, "_done16"}, i16.done, 0);
      chk({i16.cout, i16.sum} == 17'h0, {tag, "_result16"}, {i16.cout, i16.sum}, 0);
      chk({i16.fa_a, i16.fa_b, i16.fa_cin} == 9'h0, {tag, "_fa16"}, {i16.fa_a, i16.fa_b, i16.fa_cin}, 0);
      chk({i4.ready, i4.done, i4.cout, i4.sum} == 7'b1000000, {tag, "_state4"}, {i4.ready, i4.done, i4.cout, i4.sum}, 7'b1000000);
   endtask

   initial begin
      int t0, n;
      i16.start = 0; i16.op_a = 0; i16.op_b = 0; i16.cin = 0;
      i4.start = 0;  i4.op_a = 0;  i4.op_b = 0;  i4.cin = 0;
      #3 rst_n = 1'b0;
      #1 check_reset("por");
      #18 rst_n = 1'b1;
      mon_en = 1'b1;

      issue16(16'h1234, 16'h4321, 1'b0, 17'h05555, 4);
      issue16(16'hFFFF, 16'h0000, 1'b1, 17'h10000, 4);
      issue16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 4);

      // start held high, operands churning while busy
      wait_ready(1'b0);
      i16.op_a = 16'h0001; i16.op_b = 16'h0001; i16.cin = 1'b0; i16.start = 1'b1;
      exp16.push_back(17'h00002);
      for (int k = 0; k < 4; k++) nib16.push_back(nib_exp(16'h0001, 16'h0001, 1'b0, k));
      @(negedge clk);
      t0 = cyc;
      n = 0;
      do begin
         i16.op_a = 16'(n * 16'h1111 + 16'hDEAD); i16.op_b = 16'hBEEF; i16.cin = 1'b1;
         @(negedge clk);
         n++;
      end while (!i16.ready && n < 60);
      i16.op_a = 16'h8000; i16.op_b = 16'h8000; i16.cin = 1'b0;
      exp16.push_back(17'h10000);
      for (int k = 0; k < 4; k++) nib16.push_back(nib_exp(16'h8000, 16'h8000, 1'b0, k));
      @(negedge clk);
      chk(cyc - t0 == 6, "accept_spacing", cyc - t0, 6);
      i16.start = 1'b0; i16.op_a = 16'h1357; i16.op_b = 16'h2468;

      // abort mid-RUN after two steps
      issue16(16'hAAAA, 16'h5555, 1'b0, 17'h0, 2);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #2 check_reset("abort");
      @(negedge clk);
      rst_n = 1'b1;

      issue16(16'h00FF, 16'h0001, 1'b0, 17'h00100, 4);

      // narrow instance
      issue4(4'hF, 4'h1, 1'b0, 5'h10);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               issue4(4'(a), 4'(b), 1'(c), 5'(a + b + c));

      n = 0;
      while ((exp16.size() != 0 || nib16.size() != 0 || exp4.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(exp16.size() == 0 && nib16.size() == 0 && exp4.size() == 0, "drain_timeout",
          exp16.size() + nib16.size() + exp4.size(), 0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencing controller that adds two WIDTH-bit operands by time-sharing one external 4-bit ripple adder (`full_adder_4bits`), one nibble per clock, LSB nibble first. It owns the operand/carry registers and start/ready/done handshake, and drives the adder's a/b/cin inputs. The result is assembled from the adder's s/cout. It sits between a requesting datapath and the single shared 4-bit adder instance.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; NIB = WIDTH/4 nibble steps
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only on a rising edge where ready=1
- op_a  in  WIDTH  operand A, sampled on accept
- op_b  in  WIDTH  operand B, sampled on accept
- cin  in  1  carry-in, sampled on accept
- ready  out  1  high only in IDLE
- done  out  1  high for exactly one cycle (DONE state) when the result is valid
- sum  out  WIDTH  registered result; holds until the next result or reset
- cout  out  1  registered final carry; holds like sum
- fa_a  out  4  to adder input a
- fa_b  out  4  to adder input b
- fa_cin  out  1  to adder input cin
- fa_s  in  4  from adder sum, combinational
- fa_cout  in  1  from adder carry-out, combinational

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge: latch op_a into shift reg A and op_b into shift reg B. Set carry<=cin, idx<=0, go to RUN. With start=0, remain in IDLE.
- RUN drives fa_a=A[3:0], fa_b=B[3:0], fa_cin=carry. Each edge:
  - work <= {fa_s, work[WIDTH-1:4]}
  - carry <= fa_cout
  - A and B shift right by 4
  - idx <= idx+1
- RUN, at the edge where idx==NIB-1:
  - sum <= {fa_s, work[WIDTH-1:4]}
  - cout <= fa_cout
  - go to DONE
- DONE: done=1 for one cycle, then IDLE at the next edge. start is ignored in DONE.
- start in RUN or DONE is ignored. Operand inputs may change freely after accept without effect.
- In IDLE and DONE, fa_a, fa_b and fa_cin are driven 0.
- Arithmetic: {cout,sum} = op_a + op_b + cin, exact and modulo 2^(WIDTH+1). No overflow flag.
- idx width is clog2(NIB), minimum 1 bit. With WIDTH=4 (NIB=1), RUN lasts one cycle.
- ready and done decode from state only; there is no combinational path from start.

## Timing
- Reset, asynchronous on rst_n low, applies immediately regardless of state:
  - state=IDLE, ready=1, done=0
  - sum=0, cout=0
  - A, B, work, carry, idx = 0
  - fa_* = 0
- Reset mid-RUN aborts the operation: no done pulse, and the prior result is cleared to 0.
- Accept edge E0. Nibble k (0..NIB-1) is captured at edge E(k+1).
- sum and cout update at E(NIB). done is high from E(NIB) to E(NIB+1). ready returns high at E(NIB+1).
- ready is low for NIB+1 cycles. With start held high continuously, a new accept occurs every NIB+2 cycles.
- The external adder is assumed to settle in one clock period; the fa_s/fa_cout → register path is single-cycle.

## Test plan
- Reset with rst_n=0 at t=3, mid-cycle (async) → ready=1, done=0, sum=0x0000, cout=0, fa_a=fa_b=0, fa_cin=0, with no clock edge needed.
- WIDTH=16: op_a=0x1234, op_b=0x4321, cin=0, start pulse → fa_a sequence 4,3,2,1; fa_b sequence 1,2,3,4; done high exactly 4 edges after accept for one cycle; sum=0x5555, cout=0; ready high one cycle after done.
- Carry ripple: op_a=0xFFFF, op_b=0x0000, cin=1 → fa_cin sequence 1,1,1,1; sum=0x0000, cout=1. Then op_a=0xFFFF, op_b=0xFFFF, cin=1 → sum=0xFFFF, cout=1.
- start held high with changing operands (0x0001+0x0001, then 0x8000+0x8000) → accepts 6 cycles apart. Results are 0x0002/cout=0, then 0x0000/cout=1. Mid-RUN operand changes and start are ignored.
- Reset pulse after 2 RUN edges of 0xAAAA+0x5555 → immediate IDLE, sum=0, no done. Next op 0x00FF+0x0001 → sum=0x0100, cout=0.
- WIDTH=4 instance: op_a=0xF, op_b=0x1, cin=0 → done one edge after accept, sum=0x0, cout=1; random 4-bit sweep of all 512 a/b/cin combinations matches a+b+cin.
